// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with bounded hold time.
// Drives a binary owner index for a 2-to-4 decoder select, plus the
// matching one-hot grant and a valid flag, all registered.
module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] grant_idx,
  output logic       grant_valid
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       ptr_q,   ptr_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [3:0]       others;
  logic [1:0]       owner_next_ptr;
  logic [3:0]       grant_d;
  logic [1:0]       grant_idx_d;
  logic             grant_valid_d;

  // First set bit of mask, scanning circularly upward from start.
  function automatic logic [1:0] pick(input logic [3:0] mask, input logic [1:0] start);
    logic [1:0] idx;
    logic       found;
    pick  = start;
    found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = start + 2'(i);
      if (!found && mask[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  // State, pointer, hold counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      grant       <= grant_d;
      grant_idx   <= grant_idx_d;
      grant_valid <= grant_valid_d;
    end
  end

  // Next-state: release beats forced rotation beats continued hold.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    ptr_d          = ptr_q;
    cnt_d          = cnt_q;
    others         = req & ~(4'b0001 << owner_q);
    owner_next_ptr = owner_q + 2'd1;

    case (state_q)
      IDLE: begin
        if (|req) begin
          owner_d = pick(req, ptr_q);
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!req[owner_q]) begin
          ptr_d = owner_next_ptr;
          cnt_d = '0;
          if (|others) begin
            owner_d = pick(others, owner_next_ptr);
          end else begin
            state_d = IDLE;
          end
        end else if ((cnt_q == HOLD_LAST) && (|others)) begin
          owner_d = pick(others, owner_next_ptr);
          ptr_d   = owner_next_ptr;
          cnt_d   = '0;
        end else if (cnt_q != HOLD_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output encoding derived from the next owner so all outputs register together.
  always_comb begin
    grant_valid_d = (state_d == GRANT);
    grant_idx_d   = grant_valid_d ? owner_d : 2'd0;
    grant_d       = grant_valid_d ? (4'b0001 << owner_d) : 4'b0000;
  end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Scoreboard bench for rr_arbiter4: stimulus pushes hand-computed
// expectations, a monitor pops and compares after every rising edge.
module tb_rr_arbiter4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;

  typedef struct {
    int         id;
    logic       valid;
    logic [1:0] idx;
    logic [3:0] grant;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   step_id = 0;

  rr_arbiter4 #(.MAX_HOLD(8), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input logic r, input logic [3:0] q, input logic v, input logic [1:0] idx);
    exp_t e;
    @(negedge clk);
    rst = r;
    req = q;
    e.id    = step_id;
    e.valid = v;
    e.idx   = v ? idx : 2'd0;
    e.grant = v ? (4'b0001 << idx) : 4'b0000;
    exp_q.push_back(e);
    step_id++;
  endtask

  task automatic hold(input int n, input logic [3:0] q, input logic v, input logic [1:0] idx);
    for (int i = 0; i < n; i++) step(1'b0, q, v, idx);
  endtask

  // Monitor: compare registered outputs just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (grant !== e.grant || grant_idx !== e.idx || grant_valid !== e.valid) begin
          errors++;
          $display("FAIL step%0d: got grant=%b idx=%0d valid=%b, want grant=%b idx=%0d valid=%b",
                   e.id, grant, grant_idx, grant_valid, e.grant, e.idx, e.valid);
        end
      end
    end
  end

  initial begin
    int budget;
    rst = 1'b1;
    req = 4'b0000;

    // Reset holds outputs low despite requests; first grant one cycle after release.
    step(1'b1, 4'b1111, 1'b0, 2'd0);
    step(1'b1, 4'b1111, 1'b0, 2'd0);
    step(1'b0, 4'b1111, 1'b1, 2'd0);
    step(1'b1, 4'b0000, 1'b0, 2'd0);

    // Single requester holds indefinitely, then drops to idle.
    step(1'b0, 4'b0100, 1'b1, 2'd2);
    hold(20, 4'b0100, 1'b1, 2'd2);
    step(1'b0, 4'b0000, 1'b0, 2'd0);
    step(1'b0, 4'b0000, 1'b0, 2'd0);

    // Fairness: 0,1,2,3,0 with back-to-back handovers.
    step(1'b1, 4'b0000, 1'b0, 2'd0);
    hold(3, 4'b1111, 1'b1, 2'd0);
    step(1'b0, 4'b1110, 1'b1, 2'd1);
    hold(2, 4'b1111, 1'b1, 2'd1);
    step(1'b0, 4'b1101, 1'b1, 2'd2);
    hold(2, 4'b1111, 1'b1, 2'd2);
    step(1'b0, 4'b1011, 1'b1, 2'd3);
    hold(2, 4'b1111, 1'b1, 2'd3);
    step(1'b0, 4'b0111, 1'b1, 2'd0);
    step(1'b0, 4'b1111, 1'b1, 2'd0);

    // Forced rotation after exactly 8 granted cycles of requester 0.
    step(1'b1, 4'b0000, 1'b0, 2'd0);
    hold(3, 4'b0001, 1'b1, 2'd0);
    hold(5, 4'b0101, 1'b1, 2'd0);
    step(1'b0, 4'b0101, 1'b1, 2'd2);
    step(1'b0, 4'b0101, 1'b1, 2'd2);

    // Wrap 3 -> 0, skip to 1, then idle with ptr=2 so pick starts at 2.
    step(1'b1, 4'b0000, 1'b0, 2'd0);
    step(1'b0, 4'b1000, 1'b1, 2'd3);
    step(1'b0, 4'b0011, 1'b1, 2'd0);
    step(1'b0, 4'b0010, 1'b1, 2'd1);
    step(1'b0, 4'b0000, 1'b0, 2'd0);
    step(1'b0, 4'b1011, 1'b1, 2'd3);

    // Reset mid-grant drops grant; pointer returns to 0.
    step(1'b1, 4'b0000, 1'b0, 2'd0);
    step(1'b0, 4'b0010, 1'b1, 2'd1);
    step(1'b0, 4'b0010, 1'b1, 2'd1);
    step(1'b1, 4'b0010, 1'b0, 2'd0);
    step(1'b0, 4'b1010, 1'b1, 2'd1);
    step(1'b0, 4'b1010, 1'b1, 2'd1);

    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Round-robin arbiter that shares one 2-to-4-decoded resource (4 selectable targets/slaves) among 4 requesters.
- Outputs a binary owner index for the 2-bit decoder select, plus the matching one-hot grant and a valid flag.
- Supports held ownership with a bounded hold time, so one requester cannot starve the others.
- Sits between the requesting blocks and the decoder-driven resource select.

Parameters:
- MAX_HOLD, 8, maximum consecutive granted cycles before a forced rotation when another requester is waiting (legal range 2..255).
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  4  request vector; req[i] high means requester i wants the resource.
- grant  output  4  one-hot grant, registered; all zero when idle.
- grant_idx  output  2  binary index of the owner, registered; drives the decoder select w.
- grant_valid  output  1  high when grant is non-zero.

Behaviour:
- Reset (rst high at an edge):
  - grant=4'b0000, grant_idx=2'd0, grant_valid=0.
  - Priority pointer ptr=0, hold counter cnt=0, state=IDLE.
  - rst overrides every other event. Reset mid-grant drops the grant on the next edge.
- Invariants:
  - grant == (grant_valid ? (4'b0001 << grant_idx) : 4'b0000).
  - grant is never multi-hot.
- Selection function pick(mask, start): first set bit of mask, scanning circularly from index start upward (start, start+1, ..., wrapping 3→0).
- IDLE state:
  - If req==0: stay in IDLE, outputs zero.
  - Otherwise, at that edge: owner=pick(req, ptr), cnt=0, go to GRANT.
  - Latency is 1 cycle: a request sampled at edge k gives a grant visible after edge k.
- GRANT state (current owner o), evaluated each edge in this priority order:
  1. Release: if req[o]==0:
     - ptr=o+1 (mod 4).
     - If others = req & ~(1<<o) is non-zero: new owner=pick(others, o+1), cnt=0, stay in GRANT. This is a back-to-back handover with no idle cycle.
     - Else: go to IDLE, outputs zero on the next cycle.
  2. Forced rotate: if req[o]==1, cnt==MAX_HOLD-1 and others!=0:
     - new owner=pick(others, o+1), ptr=o+1, cnt=0.
  3. Continue: otherwise keep owner o.
     - cnt increments, saturating at MAX_HOLD-1.
     - If no other requester is waiting, the owner keeps the grant indefinitely.
- A new request arriving during a grant never preempts before the hold limit.
- Simultaneous release by the owner and new requests: rule 1 applies, and the handover happens at the same edge.
- Pointer wrap: o=3 gives ptr=0.
- A request pulse shorter than one cycle, or one that falls between edges, is ignored.
- Consequence of the rules: no requester waits more than 3*MAX_HOLD+1 cycles while continuously requesting.

Test Plan:
- Reset check: rst=1 for 2 cycles with req=4'b1111 → grant=0, grant_idx=0, grant_valid=0. Release rst → one cycle later grant=4'b0001, grant_idx=0.
- Single requester: req=4'b0100 from idle → next cycle grant=4'b0100, grant_idx=2. Hold req for 20 cycles → grant stays 4'b0100 (no other requester). Drop req → next cycle grant=0.
- Round-robin fairness: req=4'b1111, each owner drops its req for 1 cycle after 3 granted cycles, then re-raises it → grant_idx sequence 0,1,2,3,0 with no idle cycle between owners.
- Forced rotation, MAX_HOLD=8: req0 held continuously, req2 raised at cycle 3 of the grant → grant moves to 4'b0100 after exactly 8 granted cycles of requester 0.
- Wrap and skip: owner 3 releases while req=4'b0011 → next owner is 0, ptr=0. Then owner 0 releases with req=4'b0010 → next owner is 1.
- Reset mid-grant: owner 1 active, rst=1 for 1 cycle → grant=0. With req=4'b1010 after release of rst → grant=4'b0010 (ptr reset to 0, so 1 is the first set bit).
